// File: rtl/nr_timing_pkg.sv
// nr_timing_pkg: shared NR frame-timing definitions for the symbol timing tagger and FFT demodulator
//   FFT_LEN/CP1/CP2 helpers as functions of NFFT, frame geometry (30 kHz SCS),
//   tuser field widths and the packed timing_user_t {sfn, subframe, symbol, cp_len}.
package nr_timing_pkg;
  localparam int SFN_MAX = 1023;
  localparam int SUBFRAMES_PER_FRAME = 20;
  localparam int SYM_PER_SF = 14;
  localparam int SFN_WIDTH = 10;
  localparam int SUBFRAME_NUMBER_WIDTH = 5;
  localparam int SYMBOL_NUMBER_WIDTH = 4;
  localparam int CP_WIDTH = 5;
  typedef struct packed {
    logic [SFN_WIDTH-1:0]             sfn;
    logic [SUBFRAME_NUMBER_WIDTH-1:0] subframe;
    logic [SYMBOL_NUMBER_WIDTH-1:0]   symbol;
    logic [CP_WIDTH-1:0]              cp_len;
  } timing_user_t;
  localparam int USER_WIDTH = $bits(timing_user_t);
  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} sync_state_t;
  function automatic int fft_len(input int nfft);
    return 1 << nfft;
  endfunction
  function automatic int cp1(input int nfft);
    return 20 * (1 << nfft) / 256;
  endfunction
  function automatic int cp2(input int nfft);
    return 18 * (1 << nfft) / 256;
  endfunction
endpackage

// File: rtl/symbol_timing_tagger.sv
// symbol_timing_tagger: tags each locked sample with {sfn, subframe, symbol, cp_len} and marks symbol ends
//   clk_i, reset_ni (async active-low)
//   s_axis_in_*  : sample stream (no backpressure), SSB_start_i marks first CP sample of the SSB symbol
//   m_axis_out_* : 1-cycle registered sample with tuser metadata and tlast on the last symbol sample
//   locked_o     : high once the first sync has been seen
//   sync_err_cnt_o : misaligned resync count, built only with SYMBOL_TIMING_SYNC_ERR_CNT_EN
module symbol_timing_tagger
  import nr_timing_pkg::*;
#(
  parameter int IN_DW        = 32,
  parameter int NFFT         = 8,
  parameter int SSB_SYMBOL   = 0,
  parameter int SSB_SUBFRAME = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [IN_DW-1:0]      s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  input  logic                  SSB_start_i,
  output logic [IN_DW-1:0]      m_axis_out_tdata,
  output logic [USER_WIDTH-1:0] m_axis_out_tuser,
  output logic                  m_axis_out_tlast,
  output logic                  m_axis_out_tvalid,
  output logic                  locked_o,
  output logic [15:0]           sync_err_cnt_o
);
  localparam int CNT_W = NFFT + 2;
  localparam logic [CNT_W-1:0] FFT_LAST = CNT_W'(fft_len(NFFT) - 1);
  localparam logic [CP_WIDTH-1:0] CP1_L = CP_WIDTH'(cp1(NFFT));
  localparam logic [CP_WIDTH-1:0] CP2_L = CP_WIDTH'(cp2(NFFT));
  sync_state_t state;
  logic [SFN_WIDTH-1:0] sfn, nxt_sfn;
  logic [SUBFRAME_NUMBER_WIDTH-1:0] subframe, nxt_subframe;
  logic [SYMBOL_NUMBER_WIDTH-1:0] symbol, nxt_symbol;
  logic [CNT_W-1:0] sample_cnt, cur_cnt, nxt_cnt;
  logic resync, take, last, sym_wrap, sf_wrap;
  timing_user_t cur;
  assign resync = s_axis_in_tvalid && SSB_start_i;
  assign take = s_axis_in_tvalid && (state == LOCKED || SSB_start_i);
  // cur is the position of the incoming sample; a resync substitutes the reload values so the
  // sample is tagged with them and, being sample 0, can never carry tlast
  always_comb begin
    cur.sfn = resync ? '0 : sfn;
    cur.subframe = resync ? SUBFRAME_NUMBER_WIDTH'(SSB_SUBFRAME) : subframe;
    cur.symbol = resync ? SYMBOL_NUMBER_WIDTH'(SSB_SYMBOL) : symbol;
    cur.cp_len = cur.symbol == '0 ? CP1_L : CP2_L;
    cur_cnt = resync ? '0 : sample_cnt;
    last = cur_cnt == FFT_LAST + CNT_W'(cur.cp_len);
    sym_wrap = last && cur.symbol == SYMBOL_NUMBER_WIDTH'(SYM_PER_SF - 1);
    sf_wrap = sym_wrap && cur.subframe == SUBFRAME_NUMBER_WIDTH'(SUBFRAMES_PER_FRAME - 1);
    nxt_cnt = last ? '0 : cur_cnt + 1'b1;
    nxt_symbol = sym_wrap ? '0 : cur.symbol + SYMBOL_NUMBER_WIDTH'(last);
    nxt_subframe = sf_wrap ? '0 : cur.subframe + SUBFRAME_NUMBER_WIDTH'(sym_wrap);
    nxt_sfn = (sf_wrap && cur.sfn == SFN_WIDTH'(SFN_MAX)) ? '0 : cur.sfn + SFN_WIDTH'(sf_wrap);
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state <= UNLOCKED;
      sfn <= '0;
      subframe <= '0;
      symbol <= '0;
      sample_cnt <= '0;
      m_axis_out_tdata <= '0;
      m_axis_out_tuser <= '0;
      m_axis_out_tlast <= 1'b0;
      m_axis_out_tvalid <= 1'b0;
    end else begin
      m_axis_out_tvalid <= take;
      m_axis_out_tlast <= take && last;
      if (take) begin
        state <= LOCKED;
        sfn <= nxt_sfn;
        subframe <= nxt_subframe;
        symbol <= nxt_symbol;
        sample_cnt <= nxt_cnt;
        m_axis_out_tdata <= s_axis_in_tdata;
        m_axis_out_tuser <= cur;
      end
    end
  assign locked_o = state == LOCKED;
`ifdef SYMBOL_TIMING_SYNC_ERR_CNT_EN
  logic [15:0] err_cnt;
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) err_cnt <= '0;
    else if (resync && state == LOCKED && !(sample_cnt == '0 && symbol == SYMBOL_NUMBER_WIDTH'(SSB_SYMBOL))
             && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
  assign sync_err_cnt_o = err_cnt;
`else
  assign sync_err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_symbol_timing_tagger.sv
// tb_symbol_timing_tagger: randomized scoreboard bench for symbol_timing_tagger
module tb_symbol_timing_tagger;
  import nr_timing_pkg::*;
  localparam int SSB_SF = 18;
  localparam int SSB_SYM = 0;
  localparam int L0 = 256 + 20;
  localparam int L1 = 256 + 18;
  localparam int SLOT = L0 + 13 * L1;
  localparam int SYM_OFF = SSB_SYM == 0 ? 0 : L0 + (SSB_SYM - 1) * L1;
  logic clk_i = 1'b0, reset_ni = 1'b0;
  logic [31:0] s_axis_in_tdata, m_axis_out_tdata;
  logic s_axis_in_tvalid, SSB_start_i, m_axis_out_tlast, m_axis_out_tvalid, locked_o;
  logic [USER_WIDTH-1:0] m_axis_out_tuser;
  logic [15:0] sync_err_cnt_o;
  symbol_timing_tagger #(.IN_DW(32), .NFFT(8), .SSB_SYMBOL(SSB_SYM), .SSB_SUBFRAME(SSB_SF)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .s_axis_in_tdata(s_axis_in_tdata),
    .s_axis_in_tvalid(s_axis_in_tvalid), .SSB_start_i(SSB_start_i),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tuser(m_axis_out_tuser),
    .m_axis_out_tlast(m_axis_out_tlast), .m_axis_out_tvalid(m_axis_out_tvalid),
    .locked_o(locked_o), .sync_err_cnt_o(sync_err_cnt_o));
  always #5 clk_i = ~clk_i;
  typedef struct {logic [31:0] d; logic [USER_WIDTH-1:0] u; logic l; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, fails = 0;
  int n = 0, sfn0 = 0, sf0 = 0, exp_err = 0;
  bit m_locked = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  // position n samples after the last sync, derived from slot/symbol lengths
  function automatic void model_pos(input int idx, output logic [USER_WIDTH-1:0] u, output logic l,
                                    output bit start);
    int k, slots, off, sym, p, cp;
    k = idx + SYM_OFF;
    slots = sf0 + k / SLOT;
    off = k % SLOT;
    sym = off < L0 ? 0 : 1 + (off - L0) / L1;
    p = off < L0 ? off : (off - L0) % L1;
    cp = sym == 0 ? 20 : 18;
    u = {10'((sfn0 + slots / SUBFRAMES_PER_FRAME) % 1024), 5'(slots % SUBFRAMES_PER_FRAME), 4'(sym), 5'(cp)};
    l = p == cp + 255;
    start = p == 0 && sym == SSB_SYM;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic v, input logic s);
    logic [USER_WIDTH-1:0] u;
    logic l;
    bit st;
    @(posedge clk_i);
    #1;
    s_axis_in_tvalid = v;
    SSB_start_i = s;
    s_axis_in_tdata = $urandom;
    if (v && s) begin
      if (m_locked) begin
        model_pos(n, u, l, st);
`ifdef SYMBOL_TIMING_SYNC_ERR_CNT_EN
        if (!st && exp_err != 16'hFFFF) exp_err++;
`endif
      end
      m_locked = 1;
      n = 0;
      sfn0 = 0;
      sf0 = SSB_SF;
    end
    if (v && m_locked) begin
      model_pos(n, u, l, st);
      q.push_back('{d: s_axis_in_tdata, u: u, l: l, cyc: cyc + 1});
      n++;
    end
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (m_axis_out_tvalid) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: cyc=%0d user=%h last=%b with no sample expected", cyc,
                 m_axis_out_tuser, m_axis_out_tlast);
      end else begin
        e = q.pop_front();
        if (m_axis_out_tdata !== e.d || m_axis_out_tuser !== e.u || m_axis_out_tlast !== e.l || e.cyc != cyc) begin
          fails++;
          $display("FAIL out_sample: cyc=%0d got data=%h user=%h last=%b, expected data=%h user=%h last=%b at cyc=%0d",
                   cyc, m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast, e.d, e.u, e.l, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      fails++;
      $display("FAIL missing_output: cyc=%0d tvalid=0, expected user=%h last=%b", cyc, q[0].u, q[0].l);
      void'(q.pop_front());
    end
  end
  initial begin
    s_axis_in_tvalid = 0;
    SSB_start_i = 0;
    s_axis_in_tdata = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_tvalid", m_axis_out_tvalid, 0);
    chk("reset_tlast", m_axis_out_tlast, 0);
    chk("reset_tuser", m_axis_out_tuser, 0);
    chk("reset_tdata", m_axis_out_tdata, 0);
    chk("reset_locked", locked_o, 0);
    chk("reset_err", sync_err_cnt_o, 0);
    reset_ni = 1;
    repeat (100) send(1, 0);
    send(0, 1);
    send(0, 1);
    send(0, 0);
    send(0, 0);
    chk("unlocked_no_lock", locked_o, 0);
    send(1, 1);
    repeat (2 * SLOT + 300) send(1, 0);
    chk("locked_after_sync", locked_o, 1);
    send(1, 1);
    send(0, 0);
    force dut.sfn = 10'h3FF;
    force dut.subframe = 5'd19;
    send(0, 0);
    release dut.sfn;
    release dut.subframe;
    sfn0 = 1023;
    sf0 = 19;
    repeat (SLOT + 300) send(1, 0);
    send(1, 1);
    repeat (700) begin
      send(1, 0);
      send(0, 0);
      send(0, 0);
    end
    send(1, 1);
    repeat (L0 + 4 * L1 + 100 - 1) send(1, 0);
    send(1, 1);
    send(0, 0);
    chk("err_after_midsym_resync", sync_err_cnt_o, exp_err);
    repeat (SLOT - 1) send(1, 0);
    send(1, 1);
    send(0, 0);
    chk("err_after_aligned_resync", sync_err_cnt_o, exp_err);
    repeat (L0 - 1) send(1, 0);
    send(1, 1);
    send(0, 0);
    chk("err_after_tlast_resync", sync_err_cnt_o, exp_err);
    repeat (4000) send($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    send(0, 0);
    chk("err_after_random", sync_err_cnt_o, exp_err);
    repeat (137) send(1, 0);
    @(posedge clk_i);
    #2;
    reset_ni = 0;
    s_axis_in_tvalid = 0;
    SSB_start_i = 0;
    q.delete();
    m_locked = 0;
    exp_err = 0;
    #1;
    chk("async_rst_tvalid", m_axis_out_tvalid, 0);
    chk("async_rst_tlast", m_axis_out_tlast, 0);
    chk("async_rst_tuser", m_axis_out_tuser, 0);
    chk("async_rst_locked", locked_o, 0);
    chk("async_rst_err", sync_err_cnt_o, 0);
    @(posedge clk_i);
    #1;
    reset_ni = 1;
    repeat (50) send(1, 0);
    chk("relock_wait_unlocked", locked_o, 0);
    send(1, 1);
    repeat (600) send($urandom_range(0, 2) != 0, 0);
    repeat (4) send(0, 0);
    chk("relocked", locked_o, 1);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
